// File: rtl/pixel_stream_packer.sv
// Tags each incoming RGB pixel with its raster position and buffers it in a
// show-ahead FIFO that feeds a valid/ready word stream with sof/eol/eof markers.
module pixel_stream_packer #(
  parameter int FIFO_DEPTH = 16,
  parameter int DIM_W      = 13
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          pixel_valid,
  input  logic [7:0]                    red,
  input  logic [7:0]                    green,
  input  logic [7:0]                    blue,
  input  logic [DIM_W-1:0]              image_width,
  input  logic [DIM_W-1:0]              image_height,
  output logic [31:0]                   out_data,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_sof,
  output logic                          out_eol,
  output logic                          out_eof,
  output logic [$clog2(FIFO_DEPTH):0]   fill_level,
  output logic                          overflow,
  output logic                          frame_done
);

  localparam int PTR_W   = $clog2(FIFO_DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = 27;

  logic [DIM_W-1:0]   x_q, x_d, y_q, y_d, w_q, w_d, h_q, h_d;
  logic [ENTRY_W-1:0] mem_q [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic [ENTRY_W-1:0] head_q, head_d;
  logic               valid_q, valid_d;
  logic               overflow_q, overflow_d;
  logic               frame_done_q, frame_done_d;

  logic               x_last_s, y_last_s, sof_s;
  logic               push_s, pop_s, bypass_s;
  logic [ENTRY_W-1:0] entry_s;

  // Raster tagging, push/pop decisions and next-state for every register
  always_comb begin
    x_last_s = (x_q == w_q - DIM_W'(1));
    y_last_s = (y_q == h_q - DIM_W'(1));
    sof_s    = (x_q == DIM_W'(0)) && (y_q == DIM_W'(0));
    entry_s  = {x_last_s && y_last_s, x_last_s, sof_s, red, green, blue};

    pop_s  = valid_q && out_ready;
    push_s = pixel_valid && ((count_q < CNT_W'(FIFO_DEPTH)) || pop_s);

    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    wr_ptr_d = push_s ? (wr_ptr_q + PTR_W'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PTR_W'(1)) : rd_ptr_q;

    // The pushed pixel becomes the head when nothing older remains queued
    bypass_s = push_s && ((count_q == CNT_W'(0)) || (pop_s && (count_q == CNT_W'(1))));
    if (count_d == CNT_W'(0)) begin
      head_d = '0;
    end else if (bypass_s) begin
      head_d = entry_s;
    end else begin
      head_d = mem_q[rd_ptr_d];
    end

    x_d = x_q;
    y_d = y_q;
    w_d = w_q;
    h_d = h_q;
    if (pixel_valid) begin
      if (x_last_s) begin
        x_d = DIM_W'(0);
        y_d = y_last_s ? DIM_W'(0) : (y_q + DIM_W'(1));
      end else begin
        x_d = x_q + DIM_W'(1);
      end
    end else if (sof_s) begin
      w_d = (image_width  == DIM_W'(0)) ? DIM_W'(1) : image_width;
      h_d = (image_height == DIM_W'(0)) ? DIM_W'(1) : image_height;
    end else begin
      w_d = w_q;
      h_d = h_q;
    end

    valid_d      = (count_d != CNT_W'(0));
    overflow_d   = overflow_q || (pixel_valid && !push_s);
    frame_done_d = pop_s && head_q[26];
  end

  // Control and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      x_q          <= DIM_W'(0);
      y_q          <= DIM_W'(0);
      w_q          <= DIM_W'(1);
      h_q          <= DIM_W'(1);
      wr_ptr_q     <= PTR_W'(0);
      rd_ptr_q     <= PTR_W'(0);
      count_q      <= CNT_W'(0);
      head_q       <= '0;
      valid_q      <= 1'b0;
      overflow_q   <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      x_q          <= x_d;
      y_q          <= y_d;
      w_q          <= w_d;
      h_q          <= h_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
      head_q       <= head_d;
      valid_q      <= valid_d;
      overflow_q   <= overflow_d;
      frame_done_q <= frame_done_d;
    end
  end

  // FIFO storage, no reset needed since occupancy is tracked by count_q
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_q[wr_ptr_q] <= entry_s;
    end
  end

  assign out_data   = {8'h00, head_q[23:0]};
  assign out_sof    = head_q[24];
  assign out_eol    = head_q[25];
  assign out_eof    = head_q[26];
  assign out_valid  = valid_q;
  assign fill_level = count_q;
  assign overflow   = overflow_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_pixel_stream_packer.sv
// Directed bench for pixel_stream_packer: a queue/raster-index model is stepped
// on every clock and compared against the DUT on every falling edge.
module tb_pixel_stream_packer;

  localparam int DEPTH = 16;
  localparam int DW    = 13;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          pixel_valid = 1'b0;
  logic [7:0]    red = 8'h00, green = 8'h00, blue = 8'h00;
  logic [DW-1:0] image_width = '0, image_height = '0;
  logic [31:0]   out_data;
  logic          out_valid, out_ready = 1'b0;
  logic          out_sof, out_eol, out_eof;
  logic [4:0]    fill_level;
  logic          overflow, frame_done;

  pixel_stream_packer #(.FIFO_DEPTH(DEPTH), .DIM_W(DW)) dut (
    .clk(clk), .reset(reset), .pixel_valid(pixel_valid),
    .red(red), .green(green), .blue(blue),
    .image_width(image_width), .image_height(image_height),
    .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .fill_level(fill_level), .overflow(overflow), .frame_done(frame_done)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  logic [26:0] m_q[$];
  int          mx, my, mw, mh;
  bit          m_ovf, m_fd;

  logic [26:0] dut_log[$];
  int          fd_cnt = 0;
  int          pix = 0;
  bit          prev_stall = 1'b0;
  logic [26:0] prev_word;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [23:0] col(input int k);
    logic [7:0] v;
    v = k[7:0];
    return {v, v + 8'h40, ~v};
  endfunction

  task automatic model_reset();
    m_q.delete();
    mx = 0; my = 0; mw = 1; mh = 1;
    m_ovf = 1'b0; m_fd = 1'b0;
  endtask

  // Model: position is a linear pixel index within the frame
  task automatic model_step();
    bit pop, accept;
    logic [26:0] e;
    int idx;
    if (reset) begin
      model_reset();
    end else begin
      pop  = (m_q.size() != 0) && out_ready;
      m_fd = pop && m_q[0][26];
      accept = 1'b0;
      e = '0;
      if (pixel_valid) begin
        e = {(mx == mw - 1) && (my == mh - 1), mx == mw - 1, (mx == 0) && (my == 0), red, green, blue};
        accept = (m_q.size() < DEPTH) || pop;
        if (!accept) m_ovf = 1'b1;
        idx = my * mw + mx + 1;
        if (idx == mw * mh) idx = 0;
        mx = idx % mw;
        my = idx / mw;
      end else if (mx == 0 && my == 0) begin
        mw = (image_width == 0) ? 1 : int'(image_width);
        mh = (image_height == 0) ? 1 : int'(image_height);
      end
      if (pop) void'(m_q.pop_front());
      if (accept) m_q.push_back(e);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic send(input int n);
    logic [23:0] c;
    for (int i = 0; i < n; i++) begin
      c = col(pix);
      pixel_valid = 1'b1;
      red = c[23:16]; green = c[15:8]; blue = c[7:0];
      pix++;
      tick();
    end
    pixel_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    model_reset();
    tick(); tick();
    reset = 1'b0;
    tick(); tick();
  endtask

  task automatic wait_log(input int n, input int budget, input string name);
    for (int i = 0; i < budget && dut_log.size() < n; i++) tick();
    chk(name, dut_log.size(), n);
  endtask

  // Per-cycle comparison against the model, stall-hold check and handshake log
  always @(negedge clk) begin
    chk("out_valid", out_valid, m_q.size() != 0);
    chk("fill_level", fill_level, m_q.size());
    chk("overflow", overflow, m_ovf);
    chk("frame_done", frame_done, m_fd);
    if (m_q.size() != 0) begin
      chk("out_data", out_data, {8'h00, m_q[0][23:0]});
      chk("tags", {out_eof, out_eol, out_sof}, m_q[0][26:24]);
    end
    if (!reset && prev_stall)
      chk("hold", {out_eof, out_eol, out_sof, out_data[23:0]}, prev_word);
    prev_stall = out_valid && !out_ready && !reset;
    prev_word  = {out_eof, out_eol, out_sof, out_data[23:0]};
    if (!reset && out_valid && out_ready) dut_log.push_back(prev_word);
    if (!reset && frame_done) fd_cnt++;
  end

  initial begin
    int base;
    model_reset();
    tick(); tick();
    chk("rst_valid", out_valid, 1'b0);
    chk("rst_data", out_data, 32'h0);
    chk("rst_fill", fill_level, 5'd0);
    reset = 1'b0;

    // 4x2 frame streamed with out_ready high
    image_width = 13'd4; image_height = 13'd2;
    tick(); tick();
    dut_log.delete(); fd_cnt = 0; out_ready = 1'b1; base = pix;
    send(8);
    tick(); tick(); tick();
    chk("t1_count", dut_log.size(), 8);
    for (int i = 0; i < 8 && i < dut_log.size(); i++) begin
      chk("t1_data", dut_log[i][23:0], col(base + i));
      chk("t1_sof", dut_log[i][24], i == 0);
      chk("t1_eol", dut_log[i][25], (i == 3) || (i == 7));
      chk("t1_eof", dut_log[i][26], i == 7);
    end
    chk("t1_fd", fd_cnt, 1);
    chk("t1_ovf", overflow, 1'b0);

    // Overflow with out_ready low, then drain and next-frame alignment
    do_reset();
    out_ready = 1'b0; base = pix;
    send(16);
    chk("t2_fill16", fill_level, 5'd16);
    chk("t2_ovf_before", overflow, 1'b0);
    send(1);
    chk("t2_ovf_after", overflow, 1'b1);
    send(3);
    chk("t2_fill_sat", fill_level, 5'd16);
    dut_log.delete(); out_ready = 1'b1;
    wait_log(16, 40, "t2_drain");
    for (int i = 0; i < 16 && i < dut_log.size(); i++)
      chk("t2_order", dut_log[i][23:0], col(base + i));
    dut_log.delete();
    send(5);
    wait_log(5, 20, "t2_next");
    if (dut_log.size() == 5) begin
      chk("t2_sof_pos", {dut_log[4][24], dut_log[3][24], dut_log[0][24]}, 3'b100);
      chk("t2_eof_pos", dut_log[3][26], 1'b1);
    end

    // Full FIFO with simultaneous push and pop
    do_reset();
    out_ready = 1'b0;
    send(16);
    out_ready = 1'b1;
    send(1);
    chk("t3_fill", fill_level, 5'd16);
    chk("t3_ovf", overflow, 1'b0);
    dut_log.delete();
    wait_log(16, 40, "t3_drain");

    // 3-pixel burst with out_ready toggling
    dut_log.delete(); base = pix;
    out_ready = 1'b0; send(1);
    out_ready = 1'b0; send(1);
    out_ready = 1'b1; send(1);
    out_ready = 1'b0; tick();
    out_ready = 1'b1; tick();
    out_ready = 1'b0; tick();
    for (int i = 0; i < 4; i++) begin
      out_ready = 1'($urandom_range(0, 1));
      tick();
    end
    out_ready = 1'b1;
    wait_log(3, 20, "t4_count");
    for (int i = 0; i < 3 && i < dut_log.size(); i++)
      chk("t4_order", dut_log[i][23:0], col(base + i));

    // Reset mid-frame with words queued
    do_reset();
    out_ready = 1'b0;
    send(5);
    reset = 1'b1;
    model_reset();
    #1;
    chk("t5_valid", out_valid, 1'b0);
    chk("t5_fill", fill_level, 5'd0);
    tick();
    reset = 1'b0;
    tick(); tick();
    dut_log.delete(); out_ready = 1'b1;
    send(1);
    wait_log(1, 10, "t5_count");
    if (dut_log.size() == 1) chk("t5_sof", dut_log[0][24], 1'b1);

    // Zero geometry behaves as 1x1
    do_reset();
    image_width = 13'd0; image_height = 13'd0;
    tick(); tick();
    dut_log.delete(); fd_cnt = 0; out_ready = 1'b1;
    send(3);
    tick(); tick(); tick(); tick();
    chk("t6_count", dut_log.size(), 3);
    for (int i = 0; i < dut_log.size(); i++)
      chk("t6_tags", dut_log[i][26:24], 3'b111);
    chk("t6_fd", fd_cnt, 3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pixel_stream_packer.md
# pixel_stream_packer

Downstream stage of the ray-tracing unit. Takes the one-pixel-per-cycle RGB stream (valid strobe, no back-pressure) and tags each pixel with its raster position. Buffers the pixels in a FIFO and presents them as a valid/ready word stream with start-of-frame and end-of-line markers, for the frame-buffer writer. Also flags dropped pixels and reports frame completion.

## Interface
- FIFO_DEPTH, 16, FIFO entries; power of two, >= 4
- DIM_W, 13, width of the image dimension inputs and the x/y counters

- clk  in  1  single clock; all logic on rising edge
- reset  in  1  asynchronous, active-high; clears all state
- pixel_valid  in  1  one pixel presented this cycle; upstream cannot stall
- red, green, blue  in  8 each  pixel colour, qualified by pixel_valid
- image_width, image_height  in  DIM_W  frame geometry in pixels
- out_data  out  32  {8'h00, red, green, blue}
- out_valid  out  1  out_data/out_sof/out_eol/out_eof valid
- out_ready  in  1  consumer accepts when out_valid && out_ready
- out_sof  out  1  word is pixel (0,0) of a frame
- out_eol  out  1  word is last pixel of a row (x == width-1)
- out_eof  out  1  word is last pixel of the frame
- fill_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy
- overflow  out  1  sticky; a pixel was dropped since reset
- frame_done  out  1  one-cycle pulse after the out_eof word handshakes

## Operation
- Geometry shadow registers (w, h) load image_width/image_height on every cycle where x==0, y==0 and pixel_valid==0. They are held for the rest of the frame. An input value of 0 is treated as 1.
- Position counters x, y advance on every pixel_valid cycle, including dropped pixels, so raster alignment survives an overflow.
- x increments. At x==w-1 it wraps to 0 and y increments. At y==h-1 with x==w-1 both wrap to 0.
- Tags are computed at input from the pre-increment x and y:
  - sof = (x==0 && y==0)
  - eol = (x==w-1)
  - eof = eol && (y==h-1)
- FIFO entry is 27 bits: {eof, eol, sof, r, g, b}.
- Push when pixel_valid && (count < FIFO_DEPTH || pop this cycle). Otherwise the pixel is discarded and overflow sets; only reset clears it.
- Pop when out_valid && out_ready.
- Output is show-ahead: out_valid = (count != 0). The head entry drives out_data and the tags directly from a registered read port.
- While out_valid && !out_ready, out_data and the tags hold stable.
- frame_done is registered: it pulses for exactly one cycle, the cycle after a handshake with out_eof==1.
- fill_level = count after the current cycle's push/pop update. A simultaneous push and pop leaves it unchanged.
- Pointers are log2(FIFO_DEPTH) bits, wrap modulo depth; count is held separately.

## Timing
- Reset values: out_valid=0, out_data=0, out_sof/eol/eof=0, fill_level=0, overflow=0, frame_done=0, x=y=0, w=h=1.
- Reset asserted mid-frame discards all FIFO contents and restarts the raster at (0,0). The first pixel after release is tagged sof.
- Latency: a pixel with pixel_valid high in cycle N, pushed into an empty FIFO, gives out_valid=1 with that pixel in cycle N+1.
- With out_ready held high, throughput is one word per cycle; the FIFO never exceeds 1 entry.
- Full FIFO plus simultaneous pop: the push is accepted and nothing is dropped.
- Full FIFO with no pop: the pixel is dropped, overflow rises in cycle N+1, and the counters still advance.
- Empty FIFO plus simultaneous push: no pop occurs, since out_valid is 0 that cycle.
- A geometry change on the inputs mid-frame has no effect until the raster returns to (0,0) with an idle cycle.

## Test plan
- Reset, then w=4, h=2 and 8 consecutive pixels with out_ready=1. Required: 8 words in order with out_data=24-bit colour. sof only on word 0, eol on words 3 and 7, eof on word 7, frame_done one cycle after word 7, overflow=0.
- FIFO_DEPTH=16, out_ready=0, 20 consecutive pixels. Required: fill_level saturates at 16 and overflow=1 from the 17th pixel. Then raise out_ready: the first 16 pixels drain in order, and the next frame's sof lands on the correct pixel.
- FIFO full, then one cycle with pixel_valid=1 and out_ready=1. Required: push accepted, fill_level stays 16, overflow stays 0.
- out_ready toggled 1-0-1 at random under a 3-pixel burst. Required: out_data and the tags hold while stalled, with no duplicated or lost words.
- Reset pulsed after pixel 5 of a 4x2 frame while words are queued. Required: out_valid=0 and fill_level=0 immediately. The next pixel emerges with sof=1.
- image_width=0, image_height=0 with 3 pixels. Required: every word has sof=eol=eof=1, and frame_done pulses 3 times.
